bitserial_nn_weight_loader: RTL and testbench
=============================================

Name: bitserial_nn_weight_loader

Overview:
- AXI-Stream weight writer that drives the weight-write port of `bitserial_nn` (`w_wr_en`, `w_addr_l/h/i`, `w_data`) from a single packed weight frame.
- Generates the layer/hidden/input address sequence itself, enforces frame framing via `tlast`, and holds off while the engine is busy.
- Sits between the host DMA stream and the engine; it replaces hand-driven weight loading.

Parameters:
- DATA_W, 16: weight word width.
- N_IN, 128: inputs per neuron (innermost address, `w_addr_i`).
- N_HIDDEN, 64: neurons per layer (`w_addr_h`).
- N_LAYERS, 3: layer count (`w_addr_l`).
- FRAME_WORDS, N_LAYERS*N_HIDDEN*N_IN: derived; words per frame.
- Parameters N_IN, N_HIDDEN and N_LAYERS must each be >= 2; address widths are $clog2 of each.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  DATA_W  signed weight word.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  loader accepts beat.
- s_axis_tlast  in  1  last word of frame.
- nn_busy  in  1  engine `busy`; no weight writes while high.
- clr  in  1  synchronous clear of load_err/load_done; counters reset to 0.
- w_wr_en  out  1  weight write strobe.
- w_addr_l  out  $clog2(N_LAYERS)  layer address.
- w_addr_h  out  $clog2(N_HIDDEN)  neuron address.
- w_addr_i  out  $clog2(N_IN)  input address.
- w_data  out  DATA_W  weight data.
- load_done  out  1  level; last frame completed cleanly.
- load_err  out  1  sticky framing error.
- words_written  out  $clog2(FRAME_WORDS+1)  words written in current frame.

Behaviour:
- Reset (async, rst=1) forces:
  - all outputs to 0;
  - state LOAD;
  - address counters (l,h,i) to 0.
- Handshake is `s_axis_tvalid && s_axis_tready` sampled at posedge clk.
- States:
  - LOAD: `tready = !nn_busy`.
  - DROP: `tready = 1` regardless of nn_busy; beats are discarded and nothing is written.
- Write latency in LOAD:
  - An accepted beat produces exactly one registered write on the next cycle: `w_wr_en=1` for one cycle, with `w_data` and addresses equal to the counters at acceptance.
  - `w_wr_en=0` on every other cycle.
  - Address/data outputs hold their last value when `w_wr_en=0`.
- Counter order: i increments first, wraps N_IN-1 -> 0 and carries into h; h wraps N_HIDDEN-1 -> 0 and carries into l. Order is l-major, i-minor: flat index = (l*N_HIDDEN+h)*N_IN+i.
- words_written increments with each write and equals the flat index + 1 of the latest write.
- Clean end (final word, index FRAME_WORDS-1, accepted with tlast=1):
  - the word is written;
  - the cycle after acceptance: load_done=1, counters and words_written return to 0, state stays LOAD.
- Early tlast (tlast=1 on any index < FRAME_WORDS-1):
  - the word is still written;
  - next cycle: load_err=1, load_done=0, counters and words_written reset to 0; state stays LOAD.
- Missing tlast (index FRAME_WORDS-1 accepted with tlast=0):
  - the word is written;
  - load_err=1, counters reset, state becomes DROP.
  - DROP returns to LOAD the cycle after a beat with tlast=1 is accepted.
- load_done clears on the first accepted beat of the next frame, or on clr.
- load_err is cleared only by clr or rst.
- clr has priority over a simultaneous accepted beat: the beat is accepted and written at the current address, then counters reset to 0.
- nn_busy rising mid-frame: tready drops in the same cycle (combinational). Counters hold and the frame resumes when nn_busy falls; a write already registered still issues.
- Reset mid-frame: the partial frame is abandoned; the next beat writes address (0,0,0).
- No data arithmetic; data passes through unmodified, including sign.

Test Plan:
- Bench uses N_LAYERS=2, N_HIDDEN=4, N_IN=8 (FRAME_WORDS=64).
- Clean frame: stream 64 words, data=k (k=0..63), tlast on k=63, nn_busy=0.
  - Required: 64 writes; write k has l=k/32, h=(k/8)%4, i=k%8, data=k.
  - load_done=1 after the last write; load_err=0; words_written back to 0.
- Backpressure: raise nn_busy for 10 cycles after word 20.
  - Required: tready=0 during that window and no writes.
  - Word 21 writes (l=0,h=2,i=5) after nn_busy falls; full frame still clean.
- Early tlast: tlast on word 9.
  - Required: 10 writes, load_err=1.
  - The next word writes address (0,0,0) with load_err still 1; clr drops load_err to 0.
- Missing tlast: 64 words without tlast, then 3 extra words with tlast on the third.
  - Required: 64 writes, load_err=1, no writes for the extra words.
  - The following frame starts at (0,0,0).
- Async reset at word 30: assert rst between edges.
  - Required: w_wr_en=0 immediately and all outputs 0.
  - The next frame's first write targets (0,0,0) with data equal to the first new beat.
- Negative data: word 5 = -1 (0xFFFF) -> w_data=0xFFFF at (0,0,5).

Source files
------------

// File: rtl/bitserial_nn_weight_loader.sv
// Weight loader for bitserial_nn.
// Turns one AXI-Stream weight frame into a sequence of single-cycle writes on
// the engine's weight port. The layer/neuron/input address is generated here
// in l-major, i-minor order. Frame framing is checked against tlast, and the
// stream is stalled while the engine reports busy.
module bitserial_nn_weight_loader #(
    parameter int  DATA_W      = 16,
    parameter int  N_IN        = 128,
    parameter int  N_HIDDEN    = 64,
    parameter int  N_LAYERS    = 3,
    localparam int FRAME_WORDS = N_LAYERS * N_HIDDEN * N_IN,
    localparam int AW_L        = $clog2(N_LAYERS),
    localparam int AW_H        = $clog2(N_HIDDEN),
    localparam int AW_I        = $clog2(N_IN),
    localparam int WW_W        = $clog2(FRAME_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              nn_busy,
    input  logic              clr,
    output logic              w_wr_en,
    output logic [AW_L-1:0]   w_addr_l,
    output logic [AW_H-1:0]   w_addr_h,
    output logic [AW_I-1:0]   w_addr_i,
    output logic [DATA_W-1:0] w_data,
    output logic              load_done,
    output logic              load_err,
    output logic [WW_W-1:0]   words_written
);

    // LOAD writes accepted beats; DROP swallows the tail of an over-long
    // frame until its tlast arrives.
    typedef enum logic {
        ST_LOAD,
        ST_DROP
    } state_t;

    localparam logic [AW_H-1:0] H_MAX    = AW_H'(N_HIDDEN - 1);
    localparam logic [AW_I-1:0] I_MAX    = AW_I'(N_IN - 1);
    localparam logic [WW_W-1:0] LAST_IDX = WW_W'(FRAME_WORDS - 1);

    state_t          state;
    logic [AW_L-1:0] cnt_l;
    logic [AW_H-1:0] cnt_h;
    logic [AW_I-1:0] cnt_i;
    logic            accept;
    logic            at_last;

    // words_written always equals the flat index of the next word to be
    // written, so it doubles as the end-of-frame detector.
    assign at_last = (words_written == LAST_IDX);

    // Ready is combinational so a rising nn_busy stalls the very same cycle;
    // DROP never stalls because nothing is written to the engine.
    assign s_axis_tready = !rst && ((state == ST_DROP) || !nn_busy);
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Frame sequencer: address counters, registered write port and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_LOAD;
            cnt_l         <= '0;
            cnt_h         <= '0;
            cnt_i         <= '0;
            w_wr_en       <= 1'b0;
            w_addr_l      <= '0;
            w_addr_h      <= '0;
            w_addr_i      <= '0;
            w_data        <= '0;
            load_done     <= 1'b0;
            load_err      <= 1'b0;
            words_written <= '0;
        end else begin
            // NOTE: non-blocking assignments let the later clr branch override
            // earlier ones in the same block (last assignment wins), and the
            // default below makes w_wr_en a one-cycle strobe.
            w_wr_en <= 1'b0;

            if (accept) begin
                if (state == ST_LOAD) begin
                    w_wr_en   <= 1'b1;
                    w_addr_l  <= cnt_l;
                    w_addr_h  <= cnt_h;
                    w_addr_i  <= cnt_i;
                    w_data    <= s_axis_tdata;
                    load_done <= 1'b0;

                    if (at_last || s_axis_tlast) begin
                        // Frame ends here one way or another: rewind.
                        cnt_l         <= '0;
                        cnt_h         <= '0;
                        cnt_i         <= '0;
                        words_written <= '0;
                        if (at_last && s_axis_tlast) begin
                            load_done <= 1'b1;
                        end else begin
                            load_err <= 1'b1;
                        end
                        if (at_last && !s_axis_tlast) begin
                            state <= ST_DROP;
                        end
                    end else begin
                        words_written <= words_written + 1'b1;
                        if (cnt_i == I_MAX) begin
                            cnt_i <= '0;
                            if (cnt_h == H_MAX) begin
                                cnt_h <= '0;
                                cnt_l <= cnt_l + 1'b1;
                            end else begin
                                cnt_h <= cnt_h + 1'b1;
                            end
                        end else begin
                            cnt_i <= cnt_i + 1'b1;
                        end
                    end
                end else begin
                    // Discarded beat of an over-long frame.
                    load_done <= 1'b0;
                    if (s_axis_tlast) begin
                        state <= ST_LOAD;
                    end
                end
            end

            // Clear wins over a simultaneous beat; that beat's write above
            // still goes out at the address it was accepted on.
            if (clr) begin
                load_done     <= 1'b0;
                load_err      <= 1'b0;
                cnt_l         <= '0;
                cnt_h         <= '0;
                cnt_i         <= '0;
                words_written <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bitserial_nn_weight_loader.sv
// Self-checking bench for bitserial_nn_weight_loader (2 layers x 4 neurons x
// 8 inputs). A flat-index reference model predicts every output each cycle;
// scenario blocks add hand-computed expectations on top.
module tb_bitserial_nn_weight_loader;

    localparam int DATA_W   = 16;
    localparam int N_IN     = 8;
    localparam int N_HIDDEN = 4;
    localparam int N_LAYERS = 2;
    localparam int FW       = N_LAYERS * N_HIDDEN * N_IN;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic              s_axis_tlast = 1'b0;
    logic              nn_busy = 1'b0;
    logic              clr = 1'b0;
    logic              w_wr_en;
    logic [0:0]        w_addr_l;
    logic [1:0]        w_addr_h;
    logic [2:0]        w_addr_i;
    logic [DATA_W-1:0] w_data;
    logic              load_done;
    logic              load_err;
    logic [6:0]        words_written;

    bitserial_nn_weight_loader #(
        .DATA_W  (DATA_W),
        .N_IN    (N_IN),
        .N_HIDDEN(N_HIDDEN),
        .N_LAYERS(N_LAYERS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .nn_busy      (nn_busy),
        .clr          (clr),
        .w_wr_en      (w_wr_en),
        .w_addr_l     (w_addr_l),
        .w_addr_h     (w_addr_h),
        .w_addr_i     (w_addr_i),
        .w_data       (w_data),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (flat index arithmetic) ----------------
    int          m_idx  = 0;   // flat index of next word to write
    bit          m_drop = 0;   // discarding the tail of an over-long frame
    bit          m_acc;
    bit          e_wr   = 0;
    bit          e_done = 0;
    bit          e_err  = 0;
    int          e_l = 0, e_h = 0, e_i = 0;
    logic [15:0] e_data = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idx = 0; m_drop = 0; e_wr = 0; e_done = 0; e_err = 0;
            e_l = 0; e_h = 0; e_i = 0; e_data = '0;
        end else begin
            m_acc = s_axis_tvalid && (m_drop || !nn_busy);
            e_wr  = 0;
            if (m_acc && !m_drop) begin
                e_wr   = 1;
                e_l    = m_idx / (N_HIDDEN * N_IN);
                e_h    = (m_idx / N_IN) % N_HIDDEN;
                e_i    = m_idx % N_IN;
                e_data = s_axis_tdata;
                e_done = 0;
                if (m_idx == FW - 1) begin
                    m_idx = 0;
                    if (s_axis_tlast) e_done = 1;
                    else begin e_err = 1; m_drop = 1; end
                end else if (s_axis_tlast) begin
                    m_idx = 0;
                    e_err = 1;
                end else begin
                    m_idx++;
                end
            end else if (m_acc) begin
                e_done = 0;
                if (s_axis_tlast) m_drop = 0;
            end
            if (clr) begin
                e_err = 0; e_done = 0; m_idx = 0;
            end
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    logic [21:0] wl[$];

    always @(negedge clk) begin
        check("tready", 32'(s_axis_tready), 32'(!rst && (m_drop || !nn_busy)));
        check("w_wr_en", 32'(w_wr_en), 32'(e_wr));
        check("addr_data", 32'({w_addr_l, w_addr_h, w_addr_i, w_data}),
              32'({e_l[0], e_h[1:0], e_i[2:0], e_data}));
        check("status", 32'({load_done, load_err, words_written}),
              32'({e_done, e_err, 7'(m_idx)}));
        if (w_wr_en) wl.push_back({w_addr_l, w_addr_h, w_addr_i, w_data});
    end

    // ---------------- driver ----------------
    bit rand_busy = 0;

    task automatic cycle();
        @(negedge clk);
        #1;
        if (rand_busy) nn_busy = ($urandom_range(0, 3) == 0);
    endtask

    task automatic idle();
        cycle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Presents one beat and returns just before the edge that accepts it.
    task automatic send_beat(input logic [15:0] d, input logic last);
        int n;
        bit acc;
        repeat ($urandom_range(0, 2)) begin
            cycle();
            s_axis_tvalid = 1'b0;
        end
        cycle();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        n   = 0;
        acc = 0;
        while (!acc && n < 200) begin
            #3;
            if (s_axis_tready) acc = 1;
            else begin
                cycle();
                n++;
            end
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic do_clr();
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 32'({w_wr_en, w_addr_l, w_addr_h, w_addr_i, w_data}), 0);
        check("reset_status", 32'({load_done, load_err, words_written, s_axis_tready}), 0);
        rst = 1'b0;

        // Clean frame, data = k
        wl.delete();
        for (int k = 0; k < FW; k++) send_beat(16'(k), k == FW - 1);
        idle();
        check("clean_count", wl.size(), 64);
        for (int k = 0; k < 64 && k < wl.size(); k++)
            check("clean_write", 32'(wl[k]), 32'({1'(k / 32), 2'((k / 8) % 4), 3'(k % 8), 16'(k)}));
        check("clean_done", 32'(load_done), 1);
        check("clean_err", 32'(load_err), 0);
        check("clean_ww", 32'(words_written), 0);

        // Backpressure after word 20
        wl.delete();
        for (int k = 0; k <= 20; k++) send_beat(16'(k), 1'b0);
        cycle();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 16'd21;
        s_axis_tlast  = 1'b0;
        nn_busy       = 1'b1;
        for (int j = 0; j < 10; j++) begin
            #3;
            check("busy_tready", 32'(s_axis_tready), 0);
            cycle();
        end
        nn_busy       = 1'b0;
        s_axis_tvalid = 1'b0;
        check("busy_no_writes", wl.size(), 21);
        for (int k = 21; k < FW; k++) send_beat(16'(k), k == FW - 1);
        idle();
        check("bp_count", wl.size(), 64);
        if (wl.size() > 21) check("bp_word21", 32'(wl[21]), 32'({1'b0, 2'd2, 3'd5, 16'd21}));
        check("bp_done", 32'(load_done), 1);

        // Random data, random busy, negative word 5
        wl.delete();
        rand_busy = 1;
        for (int k = 0; k < FW; k++)
            send_beat((k == 5) ? 16'hFFFF : 16'($urandom()), k == FW - 1);
        rand_busy = 0;
        nn_busy   = 1'b0;
        idle();
        check("rand_count", wl.size(), 64);
        if (wl.size() > 5) check("neg_word5", 32'(wl[5]), 32'({1'b0, 2'd0, 3'd5, 16'hFFFF}));
        check("rand_done", 32'(load_done), 1);

        // Early tlast on word 9
        wl.delete();
        for (int k = 0; k < 10; k++) send_beat(16'($urandom()), k == 9);
        idle();
        check("early_count", wl.size(), 10);
        check("early_err", 32'(load_err), 1);
        check("early_done", 32'(load_done), 0);
        d = 16'($urandom());
        send_beat(d, 1'b0);
        idle();
        if (wl.size() > 10) check("early_restart", 32'(wl[10]), 32'({6'd0, d}));
        check("early_err_sticky", 32'(load_err), 1);
        do_clr();
        check("clr_err", 32'(load_err), 0);
        check("clr_ww", 32'(words_written), 0);

        // Missing tlast, then 3 dropped beats
        wl.delete();
        for (int k = 0; k < FW; k++) send_beat(16'($urandom()), 1'b0);
        idle();
        check("miss_count", wl.size(), 64);
        check("miss_err", 32'(load_err), 1);
        for (int k = 0; k < 3; k++) send_beat(16'($urandom()), k == 2);
        idle();
        check("drop_no_writes", wl.size(), 64);
        d = 16'($urandom());
        send_beat(d, 1'b0);
        idle();
        if (wl.size() > 64) check("miss_restart", 32'(wl[64]), 32'({6'd0, d}));
        do_clr();

        // Async reset at word 30
        for (int k = 0; k < 30; k++) send_beat(16'($urandom()), 1'b0);
        @(posedge clk);
        #2;
        check("pre_reset_wr", 32'(w_wr_en), 1);
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        check("async_rst_outputs", 32'({w_wr_en, w_addr_l, w_addr_h, w_addr_i, w_data}), 0);
        check("async_rst_status", 32'({load_done, load_err, words_written, s_axis_tready}), 0);
        cycle();
        cycle();
        rst = 1'b0;
        wl.delete();
        d = 16'($urandom());
        send_beat(d, 1'b0);
        idle();
        check("post_rst_count", wl.size(), 1);
        if (wl.size() > 0) check("post_rst_write", 32'(wl[0]), 32'({6'd0, d}));

        repeat (3) idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
